// File: rtl/guitar_pkg.sv
// Shared constants for the guitar input controller: debounce default,
// strum-mode encodings and the layout of the register-file input word.
package guitar_pkg;

  // 1 ms of stable input at a 50 MHz system clock
  localparam int DB_CYCLES_DEFAULT = 50000;

  // Strum-mode encodings
  localparam int STRUM_MODE_LEVEL   = 0;
  localparam int STRUM_MODE_LATCHED = 1;

  typedef enum logic {
    STRUM_LEVEL   = 1'b0,
    STRUM_LATCHED = 1'b1
  } strum_mode_e;

  // external_inputs layout: guitar_in starts at bit 0, hit_sticky follows
  // directly above it, everything above 2N reads as zero.
  localparam int EXT_GUITAR_LSB = 0;
  localparam int EXT_WORD_W     = 32;

  // Bit position of hit_sticky[0] for a controller with n channels
  function automatic int ext_sticky_lsb(input int n);
    return EXT_GUITAR_LSB + n;
  endfunction

  // Assemble the register-file input word from the per-channel vectors;
  // bits at or above n in either argument are masked off.
  function automatic logic [31:0] pack_external(input logic [31:0] gin,
                                                input logic [31:0] sticky,
                                                input int          n);
    logic [31:0] mask;
    mask = (32'h0000_0001 << n) - 32'h0000_0001;
    return ((gin & mask) << EXT_GUITAR_LSB) | ((sticky & mask) << ext_sticky_lsb(n));
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// One-bit two-flop synchronizer followed by a consecutive-cycle debouncer.
// The debounced state flips only after the synchronized input has disagreed
// with it for DB_CYCLES cycles in a row; any agreeing cycle restarts the count.
module input_debouncer
  import guitar_pkg::*;
#(
  parameter int   DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int   DB_W      = 16,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw_i,
  output logic db_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            db_q;
  logic            db_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // Count consecutive disagreeing cycles and flip the state on the last one
  always_comb begin
    db_d  = db_q;
    cnt_d = {DB_W{1'b0}};
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        cnt_d = {DB_W{1'b0}};
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end else begin
      cnt_d = {DB_W{1'b0}};
    end
  end

  // Synchronizer chain and debounce state; sync flops reset to the idle
  // level so no spurious count starts when reset is released.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      db_q    <= RESET_VAL;
      cnt_q   <= {DB_W{1'b0}};
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/guitar_input_ctrl.sv
// Guitar controller front end: conditions raw fret/strum lines, produces
// per-channel note levels, strike pulses and sticky strike flags, and packs
// them into a 32-bit register-file input word.
module guitar_input_ctrl
  import guitar_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_FRETS   = 3,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int DB_W        = 16,
  parameter int STRUM_MODE  = STRUM_MODE_LEVEL,
  localparam int N          = NUM_PLAYERS * NUM_FRETS
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [N-1:0]           fret_n,
  input  logic [NUM_PLAYERS-1:0] strum,
  input  logic [N-1:0]           clear,
  output logic [N-1:0]           guitar_in,
  output logic [N-1:0]           hit_pulse,
  output logic [N-1:0]           hit_sticky,
  output logic [31:0]            external_inputs
);

  logic [N-1:0]           fret_db_n_s;
  logic [N-1:0]           pressed_s;
  logic [NUM_PLAYERS-1:0] strum_db_s;
  logic [NUM_PLAYERS-1:0] strum_rise_s;

  logic [NUM_PLAYERS-1:0] strum_prev_q;
  logic [N-1:0]           cap_q;
  logic [N-1:0]           cap_d;
  logic [N-1:0]           guitar_in_q;
  logic [N-1:0]           guitar_in_d;
  logic [N-1:0]           hit_pulse_q;
  logic [N-1:0]           hit_pulse_d;
  logic [N-1:0]           hit_sticky_q;
  logic [N-1:0]           hit_sticky_d;
  logic [31:0]            ext_q;
  logic [31:0]            ext_d;

  // Fret buttons idle high (released), so their debouncers reset to 1
  for (genvar c = 0; c < N; c++) begin : g_fret_db
    input_debouncer #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W),
      .RESET_VAL (1'b1)
    ) u_fret_db (
      .clock  (clock),
      .resetn (resetn),
      .raw_i  (fret_n[c]),
      .db_o   (fret_db_n_s[c])
    );
  end

  // Strum lines idle low
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_strum_db
    input_debouncer #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W),
      .RESET_VAL (1'b0)
    ) u_strum_db (
      .clock  (clock),
      .resetn (resetn),
      .raw_i  (strum[p]),
      .db_o   (strum_db_s[p])
    );
  end

  assign pressed_s    = ~fret_db_n_s;
  assign strum_rise_s = strum_db_s & ~strum_prev_q;

  // Per-channel next state: strike pulse, captured mask, note level, sticky flag
  always_comb begin
    cap_d        = {N{1'b0}};
    guitar_in_d  = {N{1'b0}};
    hit_pulse_d  = {N{1'b0}};
    hit_sticky_d = {N{1'b0}};
    for (int c = 0; c < N; c++) begin
      // A fret debounced in the same cycle as the strum rise already counts
      hit_pulse_d[c]  = strum_rise_s[c / NUM_FRETS] & pressed_s[c];
      // Set wins over clear so a strike in the clearing cycle is not lost
      hit_sticky_d[c] = hit_pulse_q[c] | (hit_sticky_q[c] & ~clear[c]);
      if (STRUM_MODE == STRUM_MODE_LATCHED) begin
        if (strum_rise_s[c / NUM_FRETS]) begin
          cap_d[c] = pressed_s[c];
        end else if (strum_db_s[c / NUM_FRETS]) begin
          cap_d[c] = cap_q[c];
        end else begin
          cap_d[c] = 1'b0;
        end
        guitar_in_d[c] = strum_db_s[c / NUM_FRETS] & cap_d[c];
      end else begin
        cap_d[c]       = 1'b0;
        guitar_in_d[c] = pressed_s[c] & strum_db_s[c / NUM_FRETS];
      end
    end
    // Packed from the same next-state values so the word tracks the outputs
    ext_d = pack_external(32'(guitar_in_d), 32'(hit_sticky_d), N);
  end

  // Output and history registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      strum_prev_q <= {NUM_PLAYERS{1'b0}};
      cap_q        <= {N{1'b0}};
      guitar_in_q  <= {N{1'b0}};
      hit_pulse_q  <= {N{1'b0}};
      hit_sticky_q <= {N{1'b0}};
      ext_q        <= 32'h0000_0000;
    end else begin
      strum_prev_q <= strum_db_s;
      cap_q        <= cap_d;
      guitar_in_q  <= guitar_in_d;
      hit_pulse_q  <= hit_pulse_d;
      hit_sticky_q <= hit_sticky_d;
      ext_q        <= ext_d;
    end
  end

  assign guitar_in       = guitar_in_q;
  assign hit_pulse       = hit_pulse_q;
  assign hit_sticky      = hit_sticky_q;
  assign external_inputs = ext_q;

endmodule

// File: tb/tb_guitar_input_ctrl.sv
// Directed bench: level-mode and strum-latched instances share the same
// stimulus (DB_CYCLES=4) and are compared against hand-computed values.
module tb_guitar_input_ctrl;

  localparam int NP = 2;
  localparam int NF = 3;
  localparam int N  = NP * NF;

  logic          clock;
  logic          resetn;
  logic [N-1:0]  fret_n;
  logic [NP-1:0] strum;
  logic [N-1:0]  clear;

  logic [N-1:0]  gin0, pulse0, stk0;
  logic [31:0]   ext0;
  logic [N-1:0]  gin1, pulse1, stk1;
  logic [31:0]   ext1;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] acc;

  guitar_input_ctrl #(
    .NUM_PLAYERS (NP), .NUM_FRETS (NF), .DB_CYCLES (4), .DB_W (16), .STRUM_MODE (0)
  ) u_dut_lvl (
    .clock (clock), .resetn (resetn), .fret_n (fret_n), .strum (strum), .clear (clear),
    .guitar_in (gin0), .hit_pulse (pulse0), .hit_sticky (stk0), .external_inputs (ext0)
  );

  guitar_input_ctrl #(
    .NUM_PLAYERS (NP), .NUM_FRETS (NF), .DB_CYCLES (4), .DB_W (16), .STRUM_MODE (1)
  ) u_dut_lat (
    .clock (clock), .resetn (resetn), .fret_n (fret_n), .strum (strum), .clear (clear),
    .guitar_in (gin1), .hit_pulse (pulse1), .hit_sticky (stk1), .external_inputs (ext1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    fret_n = 6'h3F;
    strum  = 2'b00;
    clear  = 6'h00;
    tick(3);
    check("rst_gin0", 32'(gin0), 32'h0);
    check("rst_pulse0", 32'(pulse0), 32'h0);
    check("rst_stk1", 32'(stk1), 32'h0);
    check("rst_ext0", ext0, 32'h0);
    check("rst_ext1", ext1, 32'h0);
    resetn = 1'b1;
    tick(1);
    check("post_rst_ext0", ext0, 32'h0);
    tick(8);

    // Glitch shorter than DB_CYCLES with strum held must never show up
    strum[0] = 1'b1;
    tick(8);
    check("strum_only_pulse0", 32'(pulse0), 32'h0);
    fret_n[0] = 1'b0;
    tick(3);
    fret_n[0] = 1'b1;
    acc = 32'h0;
    repeat (10) begin
      tick(1);
      acc = acc | 32'(gin0) | 32'(pulse0) | 32'(gin1) | 32'(pulse1);
    end
    check("glitch", acc, 32'h0);
    strum[0] = 1'b0;
    tick(8);

    // Fret 1 held, strum[0] held 10 cycles
    fret_n[1] = 1'b0;
    tick(8);
    strum[0] = 1'b1;
    tick(6);
    check("m0_pre_gin0", 32'(gin0), 32'h0);
    check("m0_pre_pulse0", 32'(pulse0), 32'h0);
    tick(1);
    check("m0_pulse0", 32'(pulse0), 32'h02);
    check("m0_gin0", 32'(gin0), 32'h02);
    check("m0_pulse1", 32'(pulse1), 32'h02);
    check("m0_gin1", 32'(gin1), 32'h02);
    tick(1);
    check("m0_pulse_once", 32'(pulse0), 32'h0);
    check("m0_stk0", 32'(stk0), 32'h02);
    check("m0_ext0", ext0, 32'h0000_0082);
    check("m0_ext1", ext1, 32'h0000_0082);
    tick(2);
    check("m0_held_nopulse", 32'(pulse0), 32'h0);
    strum[0] = 1'b0;
    tick(6);
    check("m0_drop_gin0_still", 32'(gin0), 32'h02);
    tick(1);
    check("m0_drop_gin0", 32'(gin0), 32'h0);
    check("m0_drop_gin1", 32'(gin1), 32'h0);
    clear = 6'h3F;
    tick(1);
    clear = 6'h00;
    check("clr_stk0", 32'(stk0), 32'h0);
    check("clr_stk1", 32'(stk1), 32'h0);
    fret_n[1] = 1'b1;
    tick(8);

    // Frets 3,5 pressed, strum[1] rises, fret 5 released while strummed
    fret_n[3] = 1'b0;
    fret_n[5] = 1'b0;
    tick(8);
    strum[1] = 1'b1;
    tick(7);
    check("m1_gin1", 32'(gin1), 32'h28);
    check("m1_pulse1", 32'(pulse1), 32'h28);
    check("m1_pulse0", 32'(pulse0), 32'h28);
    fret_n[5] = 1'b1;
    acc = 32'h0;
    repeat (8) begin
      tick(1);
      acc = acc | 32'(pulse1);
    end
    check("m1_pulse_once", acc, 32'h0);
    check("m1_gin1_captured", 32'(gin1), 32'h28);
    check("m1_gin0_level", 32'(gin0), 32'h08);
    strum[1] = 1'b0;
    tick(6);
    check("m1_gin1_still", 32'(gin1), 32'h28);
    tick(1);
    check("m1_gin1_clear", 32'(gin1), 32'h0);
    fret_n[3] = 1'b1;
    clear = 6'h3F;
    tick(1);
    clear = 6'h00;
    tick(8);

    // Sticky set wins over a simultaneous clear
    fret_n[2] = 1'b0;
    tick(8);
    strum[0] = 1'b1;
    tick(7);
    check("stk_first_pulse", 32'(pulse0), 32'h04);
    tick(1);
    check("stk_set", 32'(stk0), 32'h04);
    strum[0] = 1'b0;
    tick(8);
    strum[0] = 1'b1;
    tick(7);
    check("stk_second_pulse", 32'(pulse0), 32'h04);
    clear = 6'h04;
    tick(1);
    check("stk_set_wins0", 32'(stk0), 32'h04);
    check("stk_set_wins1", 32'(stk1), 32'h04);
    tick(1);
    check("stk_clear_alone", 32'(stk0), 32'h0);
    clear = 6'h00;

    // Reset in the middle of a strum debounce (count 3)
    fret_n[3] = 1'b0;
    tick(8);
    check("pre_rst_ext0", ext0, 32'h0000_0004);
    strum[1] = 1'b1;
    tick(5);
    resetn = 1'b0;
    tick(1);
    check("mid_rst_gin0", 32'(gin0), 32'h0);
    check("mid_rst_pulse0", 32'(pulse0), 32'h0);
    check("mid_rst_ext0", ext0, 32'h0);
    check("mid_rst_ext1", ext1, 32'h0);
    resetn = 1'b1;
    tick(1);
    check("rel_ext0", ext0, 32'h0);
    check("rel_gin1", 32'(gin1), 32'h0);
    tick(5);
    check("rel6_gin0", 32'(gin0), 32'h0);
    check("rel6_pulse0", 32'(pulse0), 32'h0);
    tick(1);
    check("rel7_pulse0", 32'(pulse0), 32'h0C);
    check("rel7_gin0", 32'(gin0), 32'h0C);
    check("rel7_pulse1", 32'(pulse1), 32'h0C);
    check("rel7_gin1", 32'(gin1), 32'h0C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/guitar_input_ctrl.md
GUITAR_INPUT_CTRL -- requirements
Module: guitar_input_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of guitar controllers.
REQ-002 Parameter NUM_FRETS, default 3, fret buttons per controller; N = NUM_PLAYERS*NUM_FRETS, 2*N SHALL be <= 32.
REQ-003 Parameter DB_CYCLES, default 50000, stable cycles required before a debounced line changes (1 ms at 50 MHz).
REQ-004 Parameter DB_W, default 16, debounce counter width; DB_CYCLES SHALL be < 2**DB_W.
REQ-005 Parameter STRUM_MODE, default 0; 0 = level mode, 1 = strum-latched mode.
REQ-006 clock  in  1  single system clock; all logic on its rising edge.
REQ-007 resetn  in  1  reset, synchronous and active-low.
REQ-008 fret_n  in  N  raw fret buttons, active-low, asynchronous; bit p*NUM_FRETS+f = player p, fret f.
REQ-009 strum  in  NUM_PLAYERS  raw strum lines (ls), active-high, asynchronous.
REQ-010 clear  in  N  per-channel clear of hit_sticky.
REQ-011 guitar_in  out  N  conditioned per-channel note-active level.
REQ-012 hit_pulse  out  N  one-cycle strike pulse per channel.
REQ-013 hit_sticky  out  N  latched strike flags awaiting processor clear.
REQ-014 external_inputs  out  32  register-file input word: [N-1:0]=guitar_in, [2N-1:N]=hit_sticky, remaining bits 0.

Function
REQ-015 Every fret_n and strum line SHALL pass through a two-flop synchronizer before any other use.
REQ-016 Each synchronized line SHALL have a debounced state that toggles only after the synchronized value differs from it for DB_CYCLES consecutive cycles; any cycle of agreement SHALL zero that line's counter.
REQ-017 Debounce latency: a clean raw change SHALL appear on the debounced state exactly 2+DB_CYCLES cycles later; glitches shorter than DB_CYCLES SHALL never propagate.
REQ-018 Debounced fret pressed = inverse of debounced fret_n; debounced strum = debounced strum line.
REQ-019 strum_rise[p] SHALL be one cycle wide, asserted the cycle debounced strum[p] goes 0->1.
REQ-020 STRUM_MODE=0: guitar_in[c] SHALL be registered (pressed[c] AND strum_db[player(c)]), one cycle after the debounced values.
REQ-021 STRUM_MODE=1: on strum_rise[p], the player's pressed mask SHALL be captured and driven on guitar_in for that player while strum_db[p] stays 1; guitar_in SHALL clear the cycle after strum_db[p] falls; fret changes while strummed SHALL NOT alter the captured mask.
REQ-022 hit_pulse[c] SHALL assert for exactly one cycle, registered, when strum_rise[player(c)] occurs with pressed[c]=1, in both modes.
REQ-023 Fret press and strum rise debounced in the same cycle SHALL count as pressed (same-cycle debounced values used).
REQ-024 hit_sticky[c] SHALL set on hit_pulse[c] and clear on clear[c]; simultaneous set and clear SHALL leave it set.
REQ-025 A held strum SHALL produce no further hit_pulse until strum_db falls and rises again.
REQ-026 external_inputs SHALL be registered and reflect guitar_in and hit_sticky with no additional delay relative to those outputs.

Reset
REQ-027 While resetn=0 at a clock edge: synchronizer flops, debounced states (fret not pressed, strum 0), counters, captured masks, guitar_in, hit_pulse, hit_sticky and external_inputs SHALL all become 0.
REQ-028 Reset mid-debounce SHALL discard partial counts; after release the full 2+DB_CYCLES latency applies again.
REQ-029 Outputs SHALL remain 0 in the first cycle after resetn rises.

Structure
REQ-030 Shared package guitar_pkg SHALL hold DB_CYCLES default, STRUM_MODE encodings, and external_inputs field offsets.
REQ-031 One sub-module, input_debouncer (sync + counter, one bit, parameters DB_CYCLES, DB_W, RESET_VAL), SHALL be instantiated N+NUM_PLAYERS times via generate.

Verification (DB_CYCLES=4, defaults otherwise)
REQ-032 fret_n[0] low 3 cycles then high -> guitar_in, hit_pulse stay 0 (glitch rejected).
REQ-033 Mode 0: fret_n[1]=0, then strum[0]=1 held 10 cycles -> hit_pulse[1] one pulse 7 cycles after strum edge, guitar_in[1]=1 until 7 cycles after strum drops; external_inputs=32'h0000_0082 while held.
REQ-034 Mode 1: frets 3,5 pressed, strum[1] rises, then fret 5 released while strummed -> guitar_in=6'b101000 until strum falls; hit_pulse=6'b101000 once.
REQ-035 hit_sticky[2] set, clear[2] asserted in same cycle as a new hit_pulse[2] -> hit_sticky[2] stays 1; clear alone next cycle -> 0.
REQ-036 resetn=0 for 1 cycle at debounce count 3 -> all outputs 0, next press needs full 6 cycles.
